// File: rtl/booth_pkg.sv
// Shared constants, FSM state type and lane-extract helper for the Booth
// partial-product accumulator.
package booth_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int BUS_W  = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [LANE_W-1:0] lane(input logic [BUS_W-1:0] bus, input int unsigned i);
    return bus[i*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/booth_lane_adder.sv
// Combinational adder: accumulator plus LANES_PER_CYCLE lanes, wrapped to LANE_W bits.
module booth_lane_adder #(
  parameter int LANE_W          = booth_pkg::LANE_W,
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic [LANE_W-1:0]                 acc_i,
  input  logic [LANES_PER_CYCLE*LANE_W-1:0] lanes_i,
  output logic [LANE_W-1:0]                 sum_o
);

  // Two's-complement add is sign-agnostic once truncated to LANE_W bits.
  always_comb begin
    sum_o = acc_i;
    for (int k = 0; k < LANES_PER_CYCLE; k++) begin
      sum_o = sum_o + lanes_i[k*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential reducer: captures a packed Booth partial-product bus and sums its
// lanes over LANES/LANES_PER_CYCLE cycles, returning the wrapped signed product.
module booth_pp_accumulator #(
  parameter int LANES           = booth_pkg::LANES,
  parameter int LANE_W          = booth_pkg::LANE_W,
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] pp_bus,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       product,
  output logic                    busy
);

  import booth_pkg::*;

  localparam int BUS_WL = LANES * LANE_W;
  localparam int GRP_W  = LANES_PER_CYCLE * LANE_W;
  localparam int NGRP   = LANES / LANES_PER_CYCLE;
  localparam int IDX_W  = $clog2(LANES + 1);
  localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES_PER_CYCLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - LANES_PER_CYCLE);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LANE_W-1:0]  acc_q;
  logic [LANE_W-1:0]  product_q;
  logic [BUS_WL-1:0]  bus_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [GRP_W-1:0]   grp [NGRP];
  logic [GRP_W-1:0]   grp_d;
  logic [LANE_W-1:0]  sum_d;

  // Slice the captured bus into groups of lanes consumed together.
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    assign grp[gi] = bus_q[gi*GRP_W +: GRP_W];
  end

  always_comb begin
    grp_d = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (idx_q == IDX_W'(g * LANES_PER_CYCLE)) begin
        grp_d = grp[g];
      end
    end
  end

  booth_lane_adder #(
    .LANE_W          (LANE_W),
    .LANES_PER_CYCLE (LANES_PER_CYCLE)
  ) u_adder (
    .acc_i   (acc_q),
    .lanes_i (grp_d),
    .sum_o   (sum_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      bus_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      // Abort wins over everything; the last delivered product is kept.
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            bus_q      <= pp_bus;
            acc_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= sum_d;
          idx_q <= idx_q + STEP;
          if (idx_q == LAST_IDX) begin
            product_q   <= sum_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Scoreboard bench for booth_pp_accumulator at 1 and 4 lanes per cycle.
module tb_booth_pp_accumulator;
  import booth_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, flush, out_ready;
  logic [BUS_W-1:0]  pp_bus;
  logic              in_valid1, in_valid4;
  logic              in_ready1, out_valid1, busy1;
  logic              in_ready4, out_valid4, busy4;
  logic [LANE_W-1:0] product1, product4;

  int n_checks = 0;
  int n_errors = 0;
  logic [LANE_W-1:0] sb [$];
  logic [LANE_W-1:0] last_prod [2];

  booth_pp_accumulator #(.LANES(8), .LANE_W(32), .LANES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .pp_bus(pp_bus), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .product(product1), .busy(busy1)
  );

  booth_pp_accumulator #(.LANES(8), .LANE_W(32), .LANES_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .pp_bus(pp_bus), .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
    .product(product4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ov_of(input int sel);
    return (sel == 4) ? out_valid4 : out_valid1;
  endfunction
  function automatic logic ir_of(input int sel);
    return (sel == 4) ? in_ready4 : in_ready1;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 4) ? busy4 : busy1;
  endfunction
  function automatic logic [LANE_W-1:0] prod_of(input int sel);
    return (sel == 4) ? product4 : product1;
  endfunction

  // Radix-4 Booth encoder model: digit i of b times a, shifted by 2*i.
  function automatic logic [BUS_W-1:0] booth_bus(input logic signed [15:0] a, input logic signed [15:0] b);
    logic [BUS_W-1:0] bus;
    logic [16:0]      bx;
    int               d;
    logic [31:0]      pp;
    bus = '0;
    bx  = {b, 1'b0};
    for (int i = 0; i < 8; i++) begin
      d  = -2 * int'(bx[2*i+2]) + int'(bx[2*i+1]) + int'(bx[2*i]);
      pp = 32'(d * int'(a)) << (2 * i);
      bus[32*i +: 32] = pp;
    end
    return bus;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int sel, input logic [BUS_W-1:0] bus, input logic [LANE_W-1:0] exp);
    int w;
    w = 0;
    pp_bus = bus;
    while (ir_of(sel) !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("capture_wait", 64'(w < 40), 64'(1));
    if (sel == 4) in_valid4 = 1'b1;
    else          in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    sb.push_back(exp);
    pp_bus = {8{$urandom()}};
    check("busy_after_capture", 64'(busy_of(sel)), 64'(1));
    check("in_ready_after_capture", 64'(ir_of(sel)), 64'(0));
  endtask

  task automatic get_result(input int sel, input int lat);
    int c;
    int s;
    logic [LANE_W-1:0] exp;
    logic [LANE_W-1:0] got;
    c = 0;
    s = (sel == 4) ? 1 : 0;
    exp = '0;
    if (sb.size() > 0) exp = sb.pop_front();
    else check("scoreboard_empty", 64'(1), 64'(0));
    do begin
      tick();
      c++;
      if (!ov_of(sel)) check("product_hold", 64'(prod_of(sel)), 64'(last_prod[s]));
    end while (!ov_of(sel) && c < 40);
    got = prod_of(sel);
    check("latency", 64'(c), 64'(lat));
    check("product", 64'(got), 64'(exp));
    $display("op dut%0d: product=%h expected=%h latency=%0d", sel, got, exp, c);
    last_prod[s] = exp;
    if (out_ready) begin
      tick();
      check("out_valid_clear", 64'(ov_of(sel)), 64'(0));
      check("in_ready_back", 64'(ir_of(sel)), 64'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BUS_W-1:0]  buses [4];
    logic [LANE_W-1:0] exps  [4];
    logic [BUS_W-1:0]  rbus;
    logic [LANE_W-1:0] rsum;
    logic signed [15:0] ra, rb;
    logic any_ov;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_valid4 = 1'b0; pp_bus = '0;
    last_prod[0] = '0; last_prod[1] = '0;
    repeat (3) tick();
    foreach (last_prod[k]) begin
      check("rst_in_ready", 64'(ir_of(k == 0 ? 1 : 4)), 64'(1));
      check("rst_out_valid", 64'(ov_of(k == 0 ? 1 : 4)), 64'(0));
      check("rst_product", 64'(prod_of(k == 0 ? 1 : 4)), 64'(0));
      check("rst_busy", 64'(busy_of(k == 0 ? 1 : 4)), 64'(0));
    end
    rst_n = 1'b1;
    tick();

    buses[0] = booth_bus(16'sd3, 16'sd5);          exps[0] = 32'h0000000F;
    buses[1] = booth_bus(-16'sd7, 16'sd9);         exps[1] = 32'hFFFFFFC1;
    buses[2] = booth_bus(-16'sd32768, -16'sd32768); exps[2] = 32'h40000000;
    buses[3] = {8{32'hFFFFFFFF}};                  exps[3] = 32'hFFFFFFF8;

    for (int k = 0; k < 4; k++) begin
      capture(1, buses[k], exps[k]);
      get_result(1, 8);
    end
    for (int k = 0; k < 4; k++) begin
      capture(4, buses[k], exps[k]);
      get_result(4, 2);
    end

    for (int k = 0; k < 3; k++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      capture(1, booth_bus(ra, rb), 32'(int'(ra) * int'(rb)));
      get_result(1, 8);
    end
    rbus = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
    rsum = '0;
    for (int i = 0; i < LANES; i++) rsum = rsum + lane(rbus, i);
    capture(4, rbus, rsum);
    get_result(4, 2);

    // Consumer stall: result held, second request refused until drained.
    out_ready = 1'b0;
    capture(1, buses[0], exps[0]);
    get_result(1, 8);
    pp_bus = buses[1];
    in_valid1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_out_valid", 64'(out_valid1), 64'(1));
      check("stall_product", 64'(product1), 64'(exps[0]));
      check("stall_in_ready", 64'(in_ready1), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    check("drain_out_valid", 64'(out_valid1), 64'(0));
    check("drain_in_ready", 64'(in_ready1), 64'(1));
    tick();
    in_valid1 = 1'b0;
    sb.push_back(exps[1]);
    pp_bus = {8{$urandom()}};
    check("recapture_busy", 64'(busy1), 64'(1));
    get_result(1, 8);

    // Flush during the third accumulate cycle.
    capture(1, buses[1], exps[1]);
    void'(sb.pop_back());
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", 64'(out_valid1), 64'(0));
    check("flush_in_ready", 64'(in_ready1), 64'(1));
    check("flush_busy", 64'(busy1), 64'(0));
    check("flush_product_kept", 64'(product1), 64'(last_prod[0]));
    any_ov = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      any_ov = any_ov | out_valid1;
    end
    check("flush_no_out_valid", 64'(any_ov), 64'(0));
    capture(1, buses[0], exps[0]);
    get_result(1, 8);

    // flush wins over in_valid in IDLE.
    pp_bus = buses[2];
    in_valid1 = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid1 = 1'b0;
    check("flush_vs_valid_busy", 64'(busy1), 64'(0));
    check("flush_vs_valid_ready", 64'(in_ready1), 64'(1));
    tick();
    check("flush_vs_valid_busy2", 64'(busy1), 64'(0));

    // Asynchronous reset mid-accumulate.
    capture(1, buses[1], exps[1]);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready1), 64'(1));
    check("arst_out_valid", 64'(out_valid1), 64'(0));
    check("arst_product", 64'(product1), 64'(0));
    check("arst_busy", 64'(busy1), 64'(0));
    sb.delete();
    last_prod[0] = '0;
    last_prod[1] = '0;
    tick();
    rst_n = 1'b1;
    capture(1, buses[0], exps[0]);
    get_result(1, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
